serial_adder: RTL and testbench

//   Multi-cycle, parametrised ripple adder. It adds two WIDTH-bit operands plus a carry-in.

---
 rtl/serial_adder_if.sv | 24 ++
 rtl/serial_adder.sv | 149 ++++++++++++++
 tb/tb_serial_adder.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_if.sv
// Handshake and operand/result bundle for serial_adder.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             c_out;
  logic             ovf;

  modport master (
    output start, a, b, c_in,
    input  busy, done, s, c_out, ovf
  );

  modport slave (
    input  start, a, b, c_in,
    output busy, done, s, c_out, ovf
  );
endinterface

// File: rtl/serial_adder.sv
// Multi-cycle ripple adder: adds DIGIT bits per clock, LSB first,
// with a start/busy/done handshake and registered results.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic           clk,
  input  logic           rst,
  serial_adder_if.slave  bus
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("serial_adder: WIDTH must be >= 2 and divisible by DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     a_sh_q, a_sh_d;
  logic [WIDTH-1:0]     b_sh_q, b_sh_d;
  logic [WIDTH-1:0]     psum_q, psum_d;
  logic                 carry_q, carry_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 a_msb_q, a_msb_d;
  logic                 b_msb_q, b_msb_d;
  logic [WIDTH-1:0]     s_q, s_d;
  logic                 c_out_q, c_out_d;
  logic                 ovf_q, ovf_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [DIGIT-1:0]     slice_sum;
  logic                 slice_carry;
  logic                 carry_chain;
  logic [WIDTH+DIGIT-1:0] psum_shift;
  logic                 last_slice;
  logic                 accept;

  assign last_slice = (cnt_q == CW'(N - 1));
  assign accept     = (state_q == IDLE || state_q == DONE) && bus.start;
  // New slice enters from the MSB end; works even when DIGIT == WIDTH.
  assign psum_shift = {slice_sum, psum_q};

  // State, datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      psum_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      s_q     <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      psum_q  <= psum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      s_q     <= s_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Full-adder chain over the current DIGIT-bit slice
  always_comb begin
    slice_sum   = '0;
    carry_chain = carry_q;
    for (int unsigned i = 0; i < DIGIT; i++) begin
      slice_sum[i] = a_sh_q[i] ^ b_sh_q[i] ^ carry_chain;
      carry_chain  = (a_sh_q[i] & b_sh_q[i]) | (carry_chain & (a_sh_q[i] ^ b_sh_q[i]));
    end
    slice_carry = carry_chain;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (last_slice) state_d = DONE;
      DONE:    state_d = bus.start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: load on accept, shift/accumulate in RUN, publish on last slice
  always_comb begin
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    psum_d  = psum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    s_d     = s_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;
    if (accept) begin
      a_sh_d  = bus.a;
      b_sh_d  = bus.b;
      psum_d  = '0;
      carry_d = bus.c_in;
      cnt_d   = '0;
      a_msb_d = bus.a[WIDTH-1];
      b_msb_d = bus.b[WIDTH-1];
    end else if (state_q == RUN) begin
      a_sh_d  = a_sh_q >> DIGIT;
      b_sh_d  = b_sh_q >> DIGIT;
      psum_d  = psum_shift[WIDTH+DIGIT-1:DIGIT];
      carry_d = slice_carry;
      if (last_slice) begin
        s_d     = psum_shift[WIDTH+DIGIT-1:DIGIT];
        c_out_d = slice_carry;
        ovf_d   = a_msb_q ^ b_msb_q ^ psum_shift[WIDTH+DIGIT-1] ^ slice_carry;
      end else begin
        cnt_d   = cnt_q + CW'(1);
      end
    end
  end

  // Output decode from next state so busy/done come straight from flops
  always_comb begin
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.s     = s_q;
  assign bus.c_out = c_out_q;
  assign bus.ovf   = ovf_q;
endmodule

// File: tb/tb_serial_adder.sv
// Directed and swept checks for serial_adder at W=8 (D=1,4) and W=16 (D=1..16).
module tb_serial_adder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // 8-bit instances share stimulus; index 0 is D=1, index 1 is D=4
  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       cin8 = 1'b0;
  logic       busy8[2], done8[2], c8[2], ovf8[2];
  logic [7:0] s8[2];

  serial_adder_if #(.WIDTH(8)) if8_1 ();
  serial_adder_if #(.WIDTH(8)) if8_4 ();

  assign if8_1.start = start8;
  assign if8_1.a     = a8;
  assign if8_1.b     = b8;
  assign if8_1.c_in  = cin8;
  assign if8_4.start = start8;
  assign if8_4.a     = a8;
  assign if8_4.b     = b8;
  assign if8_4.c_in  = cin8;

  serial_adder #(.WIDTH(8), .DIGIT(1)) u8d1 (.clk(clk), .rst(rst), .bus(if8_1));
  serial_adder #(.WIDTH(8), .DIGIT(4)) u8d4 (.clk(clk), .rst(rst), .bus(if8_4));

  assign busy8[0] = if8_1.busy;
  assign done8[0] = if8_1.done;
  assign s8[0]    = if8_1.s;
  assign c8[0]    = if8_1.c_out;
  assign ovf8[0]  = if8_1.ovf;
  assign busy8[1] = if8_4.busy;
  assign done8[1] = if8_4.done;
  assign s8[1]    = if8_4.s;
  assign c8[1]    = if8_4.c_out;
  assign ovf8[1]  = if8_4.ovf;

  // 16-bit instances, DIGIT = 1,2,4,8,16
  logic        start16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        cin16 = 1'b0;
  logic        busy16[5], done16[5], c16[5], ovf16[5];
  logic [15:0] s16[5];

  for (genvar k = 0; k < 5; k++) begin : g16
    serial_adder_if #(.WIDTH(16)) bus16 ();
    assign bus16.start = start16;
    assign bus16.a     = a16;
    assign bus16.b     = b16;
    assign bus16.c_in  = cin16;
    serial_adder #(.WIDTH(16), .DIGIT(1 << k)) u (.clk(clk), .rst(rst), .bus(bus16));
    assign busy16[k] = bus16.busy;
    assign done16[k] = bus16.done;
    assign s16[k]    = bus16.s;
    assign c16[k]    = bus16.c_out;
    assign ovf16[k]  = bus16.ovf;
  end

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({busy8[i], done8[i], s8[i], c8[i], ovf8[i]} !== 12'h000) begin
        failures++;
        $display("FAIL reset8[%0d] got busy=%b done=%b s=%h c=%b ovf=%b exp all zero",
                 i, busy8[i], done8[i], s8[i], c8[i], ovf8[i]);
      end
    end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if ({busy16[k], done16[k], s16[k], c16[k], ovf16[k]} !== 20'h00000) begin
        failures++;
        $display("FAIL reset16[%0d] got busy=%b done=%b s=%h c=%b ovf=%b exp all zero",
                 k, busy16[k], done16[k], s16[k], c16[k], ovf16[k]);
      end
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Table of directed 8-bit vectors checked on the selected instance
  task automatic test_vectors(input int sel, input int exp_busy);
    logic [7:0] va[5] = '{8'h0F, 8'hFF, 8'h7F, 8'h00, 8'h80};
    logic [7:0] vb[5] = '{8'h01, 8'h01, 8'h01, 8'h00, 8'h80};
    logic       vc[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [7:0] es[5] = '{8'h10, 8'h00, 8'h80, 8'h01, 8'h01};
    logic       ec[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic       eo[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    int nb, t;
    for (int v = 0; v < 5; v++) begin
      a8 = va[v]; b8 = vb[v]; cin8 = vc[v]; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      nb = 0; t = 0;
      while (done8[sel] !== 1'b1 && t < 40) begin
        if (busy8[sel] === 1'b1) nb++;
        @(negedge clk);
        t++;
      end
      checks++;
      if (t >= 40) begin
        failures++;
        $display("FAIL vec_timeout sel=%0d v=%0d got no done exp done within 40 cycles", sel, v);
      end
      checks++;
      if (nb !== exp_busy) begin
        failures++;
        $display("FAIL vec_busy_cycles sel=%0d v=%0d got %0d exp %0d", sel, v, nb, exp_busy);
      end
      checks++;
      if ({busy8[sel], c8[sel], s8[sel], ovf8[sel]} !== {1'b0, ec[v], es[v], eo[v]}) begin
        failures++;
        $display("FAIL vec_result sel=%0d v=%0d got busy=%b c=%b s=%h ovf=%b exp busy=0 c=%b s=%h ovf=%b",
                 sel, v, busy8[sel], c8[sel], s8[sel], ovf8[sel], ec[v], es[v], eo[v]);
      end
      @(negedge clk);
      checks++;
      if ({done8[sel], busy8[sel], s8[sel]} !== {1'b0, 1'b0, es[v]}) begin
        failures++;
        $display("FAIL vec_done_pulse sel=%0d v=%0d got done=%b busy=%b s=%h exp done=0 busy=0 s=%h",
                 sel, v, done8[sel], busy8[sel], s8[sel], es[v]);
      end
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_start_ignored();
    int ndone;
    logic [7:0] got_s = '0;
    logic got_c = 1'b0, got_o = 1'b0;
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);              // RUN cycle 1
    start8 = 1'b0;
    @(negedge clk);              // RUN cycle 2
    @(negedge clk);              // RUN cycle 3
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    ndone = 0;
    for (int t = 0; t < 30; t++) begin
      if (done8[0] === 1'b1) begin
        ndone++;
        got_s = s8[0]; got_c = c8[0]; got_o = ovf8[0];
      end
      @(negedge clk);
    end
    checks++;
    if (ndone !== 1) begin
      failures++;
      $display("FAIL ignored_done_count got %0d exp 1", ndone);
    end
    checks++;
    if ({got_c, got_s, got_o} !== {1'b0, 8'h46, 1'b0}) begin
      failures++;
      $display("FAIL ignored_result got c=%b s=%h ovf=%b exp c=0 s=46 ovf=0", got_c, got_s, got_o);
    end
  endtask

  task automatic test_back_to_back();
    int t = 0, t1 = 0, t2 = 0;
    a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    while (done8[0] !== 1'b1 && t < 30) begin
      @(negedge clk);
      t++;
    end
    t1 = t;
    checks++;
    if (s8[0] !== 8'h02 || done8[0] !== 1'b1) begin
      failures++;
      $display("FAIL b2b_first got done=%b s=%h exp done=1 s=02", done8[0], s8[0]);
    end
    a8 = 8'h02; b8 = 8'h03;
    @(negedge clk);
    t++;
    start8 = 1'b0;
    checks++;
    if ({busy8[0], done8[0], s8[0]} !== {1'b1, 1'b0, 8'h02}) begin
      failures++;
      $display("FAIL b2b_no_idle got busy=%b done=%b s=%h exp busy=1 done=0 s=02",
               busy8[0], done8[0], s8[0]);
    end
    while (done8[0] !== 1'b1 && t < 60) begin
      @(negedge clk);
      t++;
    end
    t2 = t;
    checks++;
    if (t2 - t1 !== 9) begin
      failures++;
      $display("FAIL b2b_gap got %0d exp 9", t2 - t1);
    end
    checks++;
    if ({done8[0], c8[0], s8[0]} !== {1'b1, 1'b0, 8'h05}) begin
      failures++;
      $display("FAIL b2b_second got done=%b c=%b s=%h exp done=1 c=0 s=05", done8[0], c8[0], s8[0]);
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset_midrun();
    int ndone, nb, t;
    a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);              // RUN cycle 1
    start8 = 1'b0;
    repeat (3) @(negedge clk);   // RUN cycle 4
    checks++;
    if ({busy8[0], s8[0]} !== {1'b1, 8'h05}) begin
      failures++;
      $display("FAIL midrun_hold got busy=%b s=%h exp busy=1 s=05", busy8[0], s8[0]);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({busy8[0], done8[0], s8[0], c8[0], ovf8[0]} !== 12'h000) begin
      failures++;
      $display("FAIL midrun_reset got busy=%b done=%b s=%h c=%b ovf=%b exp all zero",
               busy8[0], done8[0], s8[0], c8[0], ovf8[0]);
    end
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8[0] === 1'b1 || busy8[0] === 1'b1) ndone++;
    end
    checks++;
    if (ndone !== 0) begin
      failures++;
      $display("FAIL midrun_discard got %0d busy/done cycles exp 0", ndone);
    end
    a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    nb = 0; t = 0;
    while (done8[0] !== 1'b1 && t < 40) begin
      if (busy8[0] === 1'b1) nb++;
      @(negedge clk);
      t++;
    end
    checks++;
    if ({nb, s8[0], c8[0], ovf8[0]} !== {32'd8, 8'h10, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL midrun_recover got busy_cycles=%0d s=%h c=%b ovf=%b exp busy_cycles=8 s=10 c=0 ovf=0",
               nb, s8[0], c8[0], ovf8[0]);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_sweep16();
    logic [16:0] exp_sum;
    logic        exp_ovf;
    logic [4:0]  got;
    int t;
    for (int v = 0; v < 200; v++) begin
      a16 = 16'($urandom);
      b16 = 16'($urandom);
      if (v == 0) begin a16 = 16'hFFFF; b16 = 16'h0000; end
      if (v == 1) begin a16 = 16'h8000; b16 = 16'h8000; end
      cin16 = 1'($urandom_range(0, 1));
      if (v < 2) cin16 = 1'b1;
      exp_sum = {1'b0, a16} + {1'b0, b16} + {16'h0000, cin16};
      exp_ovf = (a16[15] == b16[15]) && (exp_sum[15] != a16[15]);
      start16 = 1'b1;
      @(negedge clk);
      start16 = 1'b0;
      got = '0;
      t = 0;
      while (got !== 5'h1F && t < 30) begin
        for (int k = 0; k < 5; k++) begin
          if (done16[k] === 1'b1) begin
            checks++;
            if (got[k] || {c16[k], s16[k], ovf16[k]} !== {exp_sum, exp_ovf}) begin
              failures++;
              $display("FAIL sweep16 d=%0d v=%0d a=%h b=%h cin=%b got c=%b s=%h ovf=%b repeat=%b exp c=%b s=%h ovf=%b",
                       1 << k, v, a16, b16, cin16, c16[k], s16[k], ovf16[k], got[k],
                       exp_sum[16], exp_sum[15:0], exp_ovf);
            end
            got[k] = 1'b1;
          end
        end
        @(negedge clk);
        t++;
      end
      checks++;
      if (got !== 5'h1F) begin
        failures++;
        $display("FAIL sweep16_timeout v=%0d got done mask %b exp 11111", v, got);
      end
    end
  endtask

  initial begin
    test_reset();
    test_vectors(0, 8);
    test_vectors(1, 2);
    test_start_ignored();
    test_back_to_back();
    test_reset_midrun();
    test_sweep16();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
